// File: rtl/chunk_pkg.sv
// Shared definitions for the chunk buffer read-out path: default chunk geometry
// and the serializer state encoding.
package chunk_pkg;

    localparam int CHUNK_BITS = 512;
    localparam int NUM_BYTES  = CHUNK_BITS / 8;
    localparam int IDX_W      = $clog2(NUM_BYTES);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

endpackage

// File: rtl/chunk_host_tx_if.sv
// Chunk-in / byte-out handshake bundle for the chunk-to-host serializer.
// master = the serializer, slave = the surrounding chunk source and host sink.
interface chunk_host_tx_if
    import chunk_pkg::*;
#(
    parameter int num_bits = CHUNK_BITS
);
    localparam int LEN_W = $clog2(num_bits / 8) + 1;

    logic [num_bits-1:0] chunk_in;
    logic [LEN_W-1:0]    chunk_len;
    logic                chunk_valid;
    logic                chunk_ready;
    logic [7:0]          host_data;
    logic                host_valid;
    logic                host_last;
    logic                host_ready;
    logic                busy;
    logic [15:0]         bytes_sent;

    modport master (
        input  chunk_in, chunk_len, chunk_valid, host_ready,
        output chunk_ready, host_data, host_valid, host_last, busy, bytes_sent
    );

    modport slave (
        output chunk_in, chunk_len, chunk_valid, host_ready,
        input  chunk_ready, host_data, host_valid, host_last, busy, bytes_sent
    );

endinterface

// File: rtl/chunk_host_tx.sv
// Chunk-to-host serializer: latches one chunk and streams bytes k=0..len-1
// (byte k = chunk[8k+7:8k]) to the host over valid/ready.
module chunk_host_tx
    import chunk_pkg::*;
#(
    parameter int num_bits = CHUNK_BITS
)(
    input  logic             clk,
    input  logic             rst,
    chunk_host_tx_if.master  bus
);

    // Local geometry follows the instance width rather than the package default.
    localparam int NB = num_bits / 8;
    localparam int IW = $clog2(NB);
    localparam int LW = IW + 1;

    state_t              state_r;
    logic [num_bits-1:0] shreg_r;
    logic [IW-1:0]       idx_r;
    logic [LW-1:0]       len_r;
    logic [15:0]         bytes_sent_r;
    logic                last_s;

    // Widened compare so a full-length chunk ends at idx=NB-1 without wrap trouble.
    assign last_s = (state_r == ST_SEND) && ({1'b0, idx_r} == (len_r - LW'(1)));

    assign bus.chunk_ready = (state_r == ST_IDLE);
    assign bus.host_valid  = (state_r == ST_SEND);
    assign bus.busy        = (state_r == ST_SEND);
    assign bus.host_data   = shreg_r[7:0];
    assign bus.host_last   = last_s;
    assign bus.bytes_sent  = bytes_sent_r;

    // Serializer FSM, shift register and byte counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            shreg_r      <= '0;
            idx_r        <= '0;
            len_r        <= '0;
            bytes_sent_r <= 16'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (bus.chunk_valid) begin
                        shreg_r <= bus.chunk_in;
                        len_r   <= (bus.chunk_len == '0) ? LW'(NB) : bus.chunk_len;
                        idx_r   <= '0;
                        state_r <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (bus.host_ready) begin
                        // Shifting keeps the output byte at a fixed position, no wide mux.
                        shreg_r      <= {8'h00, shreg_r[num_bits-1:8]};
                        idx_r        <= idx_r + IW'(1);
                        bytes_sent_r <= bytes_sent_r + 16'd1;
                        if (last_s) begin
                            state_r <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_chunk_host_tx.sv
// Self-checking bench for chunk_host_tx: directed scenarios plus random chunks,
// checked each cycle against a byte-queue reference model.
module tb_chunk_host_tx;
    import chunk_pkg::*;

    localparam int NB = CHUNK_BITS / 8;

    typedef struct {
        logic [7:0] d;
        logic       l;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    chunk_host_tx_if #(.num_bits(CHUNK_BITS)) bus ();

    chunk_host_tx #(.num_bits(CHUNK_BITS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int                  checks = 0;
    int                  errors = 0;
    exp_t                exp_q[$];
    logic [15:0]         exp_sent = 16'd0;
    logic [CHUNK_BITS-1:0] cur_chunk;
    int                  cur_len;
    logic                accepted;
    logic                drop_valid;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
            $error("%s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [CHUNK_BITS-1:0] rand_chunk();
        logic [CHUNK_BITS-1:0] c;
        for (int i = 0; i < CHUNK_BITS / 32; i++) c[32*i +: 32] = $urandom;
        return c;
    endfunction

    // One clock: set host_ready, check outputs against the model, advance the model.
    task automatic step(input logic rdy);
        logic hs;
        int   eff;
        hs = 1'b0;
        bus.host_ready = rdy;
        @(negedge clk);
        chk("chunk_ready", 32'(bus.chunk_ready), 32'(exp_q.size() == 0));
        chk("host_valid",  32'(bus.host_valid),  32'(exp_q.size() != 0));
        chk("busy",        32'(bus.busy),        32'(exp_q.size() != 0));
        chk("bytes_sent",  32'(bus.bytes_sent),  32'(exp_sent));
        if (exp_q.size() != 0) begin
            chk("host_data", 32'(bus.host_data), 32'(exp_q[0].d));
            chk("host_last", 32'(bus.host_last), 32'(exp_q[0].l));
            if (rdy) begin
                void'(exp_q.pop_front());
                exp_sent = exp_sent + 16'd1;
            end
        end else begin
            chk("host_last_idle", 32'(bus.host_last), 32'd0);
            if (bus.chunk_valid) begin
                eff = (cur_len == 0) ? NB : cur_len;
                for (int k = 0; k < eff; k++) exp_q.push_back('{cur_chunk[8*k +: 8], (k == eff - 1)});
                hs = 1'b1;
                accepted = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        if (hs && drop_valid) bus.chunk_valid = 1'b0;
    endtask

    task automatic offer(input logic [CHUNK_BITS-1:0] data, input int len);
        cur_chunk       = data;
        cur_len         = len;
        bus.chunk_in    = data;
        bus.chunk_len   = 7'(len);
        bus.chunk_valid = 1'b1;
        accepted        = 1'b0;
    endtask

    // mode 0: always ready, 1: ready pattern 1,0,0 repeating, 2: random ready
    task automatic run_chunk(input logic [CHUNK_BITS-1:0] data, input int len, input int mode);
        int n;
        logic r;
        drop_valid = 1'b1;
        offer(data, len);
        n = 0;
        while (!(accepted && exp_q.size() == 0) && n < 2000) begin
            case (mode)
                0: r = 1'b1;
                1: r = ((n % 3) == 0);
                default: r = 1'($urandom_range(0, 1));
            endcase
            step(r);
            n++;
        end
        chk("chunk_accepted", 32'(accepted), 32'd1);
        chk("chunk_drained", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.chunk_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        exp_sent = 16'd0;
    endtask

    initial begin
        logic [CHUNK_BITS-1:0] c;
        logic [CHUNK_BITS-1:0] b_chunk;
        int n;

        bus.chunk_valid = 1'b0;
        bus.chunk_in    = '0;
        bus.chunk_len   = '0;
        bus.host_ready  = 1'b0;
        drop_valid      = 1'b1;
        cur_chunk       = '0;
        cur_len         = 0;
        accepted        = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("reset_host_data", 32'(bus.host_data), 32'd0);
        @(posedge clk);
        #1;
        step(1'b0);

        // Reset in the middle of a chunk after three bytes.
        offer(rand_chunk(), 10);
        step(1'b1);
        repeat (3) step(1'b1);
        chk("pre_reset_sent", 32'(bus.bytes_sent), 32'd3);
        do_reset();
        repeat (4) step(1'b1);

        // Full chunk, byte k = k, len 0 meaning all bytes.
        for (int k = 0; k < NB; k++) c[8*k +: 8] = 8'(k);
        run_chunk(c, 0, 0);
        chk("full_chunk_sent", 32'(bus.bytes_sent), 32'd64);

        // Single-byte chunk.
        c = rand_chunk();
        c[7:0] = 8'hA5;
        run_chunk(c, 1, 0);
        step(1'b1);

        // Stalling host on a 5-byte chunk.
        run_chunk(rand_chunk(), 5, 1);

        // Back-to-back chunks with chunk_valid held high.
        drop_valid = 1'b0;
        offer(rand_chunk(), 7);
        step(1'b1);
        b_chunk = rand_chunk();
        drop_valid = 1'b1;
        offer(b_chunk, 4);
        n = 0;
        while (!(accepted && exp_q.size() == 0) && n < 200) begin
            step(1'b1);
            n++;
        end
        chk("b2b_drained", 32'(exp_q.size()), 32'd0);
        chk("b2b_accepted", 32'(accepted), 32'd1);

        // Random lengths with random host back-pressure.
        for (int i = 0; i < 30; i++) run_chunk(rand_chunk(), $urandom_range(0, NB), 2);

        // Long run: byte counter wraps at 2^16.
        do_reset();
        for (int i = 0; i < 1100; i++) run_chunk(rand_chunk(), NB, 0);
        chk("wrap_bytes_sent", 32'(bus.bytes_sent), 32'd4864);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
